zet_umi_mem8_slave: RTL and testbench

ZET_UMI_MEM8_SLAVE -- requirements
Module: zet_umi_mem8_slave

---
 rtl/zet_umi_mem8_slave.sv | 213 +++++++++++++++++++++
 tb/tb_zet_umi_mem8_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zet_umi_mem8_slave.sv
// zet_umi_mem8_slave
//   Bridges a 16-bit UMI request/ack responder port onto an asynchronous
//   8-bit memory. Word accesses are split into two byte phases (adr, adr+1)
//   separated by a one-cycle idle gap on the memory strobes. Each byte phase
//   holds the strobes for WAIT_STATES+1 clocks.
//
// Parameters
//   WAIT_STATES  0..15  extra clocks each byte strobe is held beyond one
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active-low
//   umi_adr_i    byte address of the request
//   umi_dat_i    write data (byte access uses [7:0])
//   umi_dat_o    read data, held until the next read completes
//   umi_we_i     1 = write, 0 = read
//   umi_by_i     1 = byte access, 0 = word access
//   umi_stb_i    request, sampled only while idle
//   umi_ack_o    one-cycle completion pulse
//   mem_adr_o    memory byte address
//   mem_dat_i    memory read data
//   mem_dat_o    memory write data
//   mem_ce_n_o   chip enable, active-low
//   mem_oe_n_o   output enable, active-low
//   mem_we_n_o   write enable, active-low
//
// Optional feature
//   ZET_UMI_MEM8_WP_EN  when defined, write bytes addressed at or above
//                       0xF0000 keep mem_we_n_o high (ce, timing and ack
//                       are unaffected).

module zet_umi_mem8_slave #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] umi_adr_i,
  input  logic [15:0] umi_dat_i,
  output logic [15:0] umi_dat_o,
  input  logic        umi_we_i,
  input  logic        umi_by_i,
  input  logic        umi_stb_i,
  output logic        umi_ack_o,
  output logic [19:0] mem_adr_o,
  input  logic [7:0]  mem_dat_i,
  output logic [7:0]  mem_dat_o,
  output logic        mem_ce_n_o,
  output logic        mem_oe_n_o,
  output logic        mem_we_n_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BYTE,
    S_GAP,
    S_ACK
  } state_e;

  localparam logic [3:0]  W_LAST  = 4'(WAIT_STATES);
  localparam logic [19:0] WP_BASE = 20'hF0000;

`ifdef ZET_UMI_MEM8_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  function automatic logic wr_allowed(input logic [19:0] a);
    return !(WP_EN && (a >= WP_BASE));
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hi_q, hi_d;          // 1 while servicing byte 1 of a word
  logic [19:0] adr_q, adr_d;
  logic [7:0]  dat_hi_q, dat_hi_d;  // byte 1 of write data, used after the gap
  logic        we_q, we_d;
  logic        by_q, by_d;
  logic [7:0]  rd_lo_q, rd_lo_d;    // byte 0 of a word read, published at ack
  logic [15:0] umi_dat_q, umi_dat_d;
  logic        ack_q, ack_d;
  logic [19:0] mem_adr_q, mem_adr_d;
  logic [7:0]  mem_dat_q, mem_dat_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic [19:0] adr_nxt;

  assign umi_dat_o  = umi_dat_q;
  assign umi_ack_o  = ack_q;
  assign mem_adr_o  = mem_adr_q;
  assign mem_dat_o  = mem_dat_q;
  assign mem_ce_n_o = ce_n_q;
  assign mem_oe_n_o = oe_n_q;
  assign mem_we_n_o = we_n_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    adr_d     = adr_q;
    dat_hi_d  = dat_hi_q;
    we_d      = we_q;
    by_d      = by_q;
    rd_lo_d   = rd_lo_q;
    umi_dat_d = umi_dat_q;
    ack_d     = 1'b0;
    mem_adr_d = mem_adr_q;
    mem_dat_d = mem_dat_q;
    ce_n_d    = ce_n_q;
    oe_n_d    = oe_n_q;
    we_n_d    = we_n_q;
    // 20-bit add wraps 0xFFFFF -> 0x00000 naturally
    adr_nxt   = adr_q + 20'd1;

    unique case (state_q)
      S_IDLE: begin
        if (umi_stb_i) begin
          state_d   = S_BYTE;
          cnt_d     = '0;
          hi_d      = 1'b0;
          adr_d     = umi_adr_i;
          dat_hi_d  = umi_dat_i[15:8];
          we_d      = umi_we_i;
          by_d      = umi_by_i;
          mem_adr_d = umi_adr_i;
          mem_dat_d = umi_dat_i[7:0];
          ce_n_d    = 1'b0;
          oe_n_d    = umi_we_i;
          we_n_d    = !(umi_we_i && wr_allowed(umi_adr_i));
        end
      end

      S_BYTE: begin
        if (cnt_q == W_LAST) begin
          // Leaving the byte phase: this is the read-data capture edge
          cnt_d  = '0;
          ce_n_d = 1'b1;
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          if (!hi_q && !by_q) begin
            state_d = S_GAP;
            rd_lo_d = mem_dat_i;
          end else begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            if (!we_q) begin
              umi_dat_d = by_q ? {8'h00, mem_dat_i} : {mem_dat_i, rd_lo_q};
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_GAP: begin
        state_d   = S_BYTE;
        hi_d      = 1'b1;
        cnt_d     = '0;
        mem_adr_d = adr_nxt;
        mem_dat_d = dat_hi_q;
        ce_n_d    = 1'b0;
        oe_n_d    = we_q;
        we_n_d    = !(we_q && wr_allowed(adr_nxt));
      end

      S_ACK: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 1'b0;
      adr_q     <= '0;
      dat_hi_q  <= '0;
      we_q      <= 1'b0;
      by_q      <= 1'b0;
      rd_lo_q   <= '0;
      umi_dat_q <= '0;
      ack_q     <= 1'b0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      adr_q     <= adr_d;
      dat_hi_q  <= dat_hi_d;
      we_q      <= we_d;
      by_q      <= by_d;
      rd_lo_q   <= rd_lo_d;
      umi_dat_q <= umi_dat_d;
      ack_q     <= ack_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
    end
  end

endmodule

// File: tb/tb_zet_umi_mem8_slave.sv
// Testbench for zet_umi_mem8_slave: one instance with WAIT_STATES=2 and one
// with WAIT_STATES=0, each attached to a byte-wide memory model.

module tb_zet_umi_mem8_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [19:0] adr2, madr2;
  logic [15:0] wdat2, rdat2;
  logic        we2, by2, stb2, ack2, ce2, oe2, wen2;
  logic [7:0]  mdi2, mdo2;

  logic [19:0] adr0, madr0;
  logic [15:0] wdat0, rdat0;
  logic        we0, by0, stb0, ack0, ce0, oe0, wen0;
  logic [7:0]  mdi0, mdo0;

  zet_umi_mem8_slave #(.WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst),
    .umi_adr_i(adr2), .umi_dat_i(wdat2), .umi_dat_o(rdat2),
    .umi_we_i(we2), .umi_by_i(by2), .umi_stb_i(stb2), .umi_ack_o(ack2),
    .mem_adr_o(madr2), .mem_dat_i(mdi2), .mem_dat_o(mdo2),
    .mem_ce_n_o(ce2), .mem_oe_n_o(oe2), .mem_we_n_o(wen2)
  );

  zet_umi_mem8_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .umi_adr_i(adr0), .umi_dat_i(wdat0), .umi_dat_o(rdat0),
    .umi_we_i(we0), .umi_by_i(by0), .umi_stb_i(stb0), .umi_ack_o(ack0),
    .mem_adr_o(madr0), .mem_dat_i(mdi0), .mem_dat_o(mdo0),
    .mem_ce_n_o(ce0), .mem_oe_n_o(oe0), .mem_we_n_o(wen0)
  );

  // Memory models: combinational read, write on rising edge while ce/we low
  logic [7:0]  mem2 [0:1048575];
  logic [7:0]  mem0 [0:1048575];
  logic        poke_en = 1'b0;
  logic        poke_sel = 1'b0;
  logic [19:0] poke_adr = '0;
  logic [7:0]  poke_dat = '0;

  assign mdi2 = mem2[madr2];
  assign mdi0 = mem0[madr0];

  always @(posedge clk) begin
    if (poke_en && poke_sel)  mem2[poke_adr] <= poke_dat;
    if (poke_en && !poke_sel) mem0[poke_adr] <= poke_dat;
    if (!ce2 && !wen2) mem2[madr2] <= mdo2;
    if (!ce0 && !wen0) mem0[madr0] <= mdo0;
  end

  typedef struct {
    logic [15:0] dat;
    int          sample;
    int          lat;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   we_lo2 = 0;
  int   acks2 = 0;
  logic ack2_d = 1'b0;
  logic ack0_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented
  always @(negedge clk) begin
    if (!ce2 && !wen2) we_lo2 <= we_lo2 + 1;
    if (!ce2) chk("strobe2_excl", 32'(!oe2 && !wen2), 0);
    if (!ce0) chk("strobe0_excl", 32'(!oe0 && !wen0), 0);
    if (ack2_d) chk("ack2_width", 32'(ack2), 0);
    if (ack0_d) chk("ack0_width", 32'(ack0), 0);
    if (ack2) begin
      acks2 <= acks2 + 1;
      chk("ack2_expected", 32'(q2.size() != 0), 1);
      if (q2.size() != 0) begin
        chk("rd2_dat", 32'(rdat2), 32'(q2[0].dat));
        chk("lat2", 32'(cyc - q2[0].sample), 32'(q2[0].lat));
        void'(q2.pop_front());
      end
    end
    if (ack0) begin
      chk("ack0_expected", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) begin
        chk("rd0_dat", 32'(rdat0), 32'(q0[0].dat));
        chk("lat0", 32'(cyc - q0[0].sample), 32'(q0[0].lat));
        void'(q0.pop_front());
      end
    end
    ack2_d <= ack2;
    ack0_d <= ack0;
  end

  task automatic poke(input logic sel, input logic [19:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_sel = sel; poke_adr = a; poke_dat = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One request, stb held for the sampling edge only; waits for ack (bounded)
  task automatic issue(input int d, input logic [19:0] a, input logic [15:0] wd,
                       input logic we, input logic by, input logic [15:0] exp, input int lat);
    int   n;
    logic got;
    @(negedge clk);
    if (d == 2) begin
      adr2 = a; wdat2 = wd; we2 = we; by2 = by; stb2 = 1'b1;
      q2.push_back('{exp, cyc + 1, lat});
    end else begin
      adr0 = a; wdat0 = wd; we0 = we; by0 = by; stb0 = 1'b1;
      q0.push_back('{exp, cyc + 1, lat});
    end
    @(negedge clk);
    stb2 = 1'b0;
    stb0 = 1'b0;
    got = (d == 2) ? ack2 : ack0;
    n = 0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = (d == 2) ? ack2 : ack0;
      n++;
    end
    chk("ack_seen", 32'(got), 1);
    @(negedge clk);
  endtask

  logic [15:0] fetch_exp [4];
  int          w0, a0, s, n;

  initial begin
    fetch_exp = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};
    rst = 1'b0;
    adr2 = '0; wdat2 = '0; we2 = 1'b0; by2 = 1'b0; stb2 = 1'b0;
    adr0 = '0; wdat0 = '0; we0 = 1'b0; by0 = 1'b0; stb0 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack2", 32'(ack2), 0);
    chk("rst_dat2", 32'(rdat2), 0);
    chk("rst_adr2", 32'(madr2), 0);
    chk("rst_mdo2", 32'(mdo2), 0);
    chk("rst_strb2", 32'({ce2, oe2, wen2}), 32'h7);
    chk("rst_ack0", 32'(ack0), 0);
    chk("rst_strb0", 32'({ce0, oe0, wen0}), 32'h7);
    @(negedge clk);
    rst = 1'b1;

    poke(1'b1, 20'h12345, 8'hCD);
    poke(1'b1, 20'h12346, 8'hAB);
    poke(1'b1, 20'h00401, 8'h11);
    poke(1'b1, 20'h00402, 8'h3C);
    poke(1'b1, 20'hF0000, 8'h77);
    for (int i = 0; i < 8; i++) poke(1'b1, 20'h02000 + 20'(i), 8'h10 + 8'(i));
    poke(1'b0, 20'hFFFFF, 8'h34);
    poke(1'b0, 20'h00000, 8'h12);

    // Word read, W=2
    issue(2, 20'h12345, 16'h0000, 1'b0, 1'b0, 16'hABCD, 7);
    // Byte read returns zero-extended byte
    issue(2, 20'h12346, 16'h0000, 1'b0, 1'b1, 16'h00AB, 3);
    // Byte write: read data must not change
    w0 = we_lo2;
    issue(2, 20'h00400, 16'h125A, 1'b1, 1'b1, 16'h00AB, 3);
    chk("bw_we_cycles", 32'(we_lo2 - w0), 3);
    chk("bw_mem", 32'(mem2[20'h00400]), 32'h5A);
    // Word write straddling the protected boundary
    issue(2, 20'hEFFFF, 16'hBEEF, 1'b1, 1'b0, 16'h00AB, 7);
    chk("ww_lo", 32'(mem2[20'hEFFFF]), 32'hEF);
`ifdef ZET_UMI_MEM8_WP_EN
    chk("ww_hi_prot", 32'(mem2[20'hF0000]), 32'h77);
`else
    chk("ww_hi", 32'(mem2[20'hF0000]), 32'hBE);
`endif
    // Odd-address word read
    issue(2, 20'h00401, 16'h0000, 1'b0, 1'b0, 16'h3C11, 7);

    // Fetch-style: stb held high, address advanced by 2 after each ack
    @(negedge clk);
    adr2 = 20'h02000; we2 = 1'b0; by2 = 1'b0; stb2 = 1'b1;
    q2.push_back('{fetch_exp[0], cyc + 1, 7});
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack2 && n < 60);
      chk("fetch_ack_seen", 32'(ack2), 1);
      if (k < 3) begin
        adr2 = adr2 + 20'd2;
        q2.push_back('{fetch_exp[k + 1], cyc + 2, 7});
      end else begin
        stb2 = 1'b0;
      end
    end
    @(negedge clk);

    // W=0: word read wraps to address 0, then byte read at 0
    issue(0, 20'hFFFFF, 16'h0000, 1'b0, 1'b0, 16'h1234, 3);
    issue(0, 20'h00000, 16'h0000, 1'b0, 1'b1, 16'h0012, 1);

    // Reset during the gap of a word read
    @(negedge clk);
    adr2 = 20'h12345; we2 = 1'b0; by2 = 1'b0; stb2 = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    stb2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("gap_cycle", 32'(cyc - s), 3);
    chk("gap_strobes", 32'({ce2, oe2, wen2}), 32'h7);
    chk("gap_adr", 32'(madr2), 32'h12345);
    #1 rst = 1'b0;
    #1;
    chk("arst_strobes", 32'({ce2, oe2, wen2}), 32'h7);
    chk("arst_ack", 32'(ack2), 0);
    chk("arst_dat", 32'(rdat2), 0);
    chk("arst_adr", 32'(madr2), 0);
    a0 = acks2;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_ack_after_rst", 32'(acks2 - a0), 0);
    issue(2, 20'h12345, 16'h0000, 1'b0, 1'b1, 16'h00CD, 3);

    repeat (2) @(negedge clk);
    chk("q2_drained", 32'(q2.size()), 0);
    chk("q0_drained", 32'(q0.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
